// File: rtl/exu_pkg.sv
// exu_pkg: operation encodings and helpers shared by the execution unit.
// Optional multiply ops are enabled by the EXU_MUL_EN macro.
package exu_pkg;

  localparam int OP_W = 5;

  typedef enum logic [OP_W-1:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_AND    = 5'd2,
    OP_OR     = 5'd3,
    OP_XOR    = 5'd4,
    OP_SLL    = 5'd5,
    OP_SRL    = 5'd6,
    OP_SRA    = 5'd7,
    OP_SLT    = 5'd8,
    OP_SLTU   = 5'd9,
    OP_LUI    = 5'd10,
    OP_BEQ    = 5'd11,
    OP_BNE    = 5'd12,
    OP_BLT    = 5'd13,
    OP_BGE    = 5'd14,
    OP_BLTU   = 5'd15,
    OP_BGEU   = 5'd16,
    OP_MUL    = 5'd17,
    OP_MULH   = 5'd18,
    OP_MULHSU = 5'd19,
    OP_MULHU  = 5'd20
  } op_e;

  // Number of operand-B bits that form a shift amount for a given width.
  function automatic int shamt_w(input int xlen);
    return $clog2(xlen);
  endfunction

endpackage

// File: rtl/exu_alu_core.sv
// exu_alu_core: purely combinational integer compute. With EXU_MUL_EN
// defined it also produces the first (partial-product) half of a multiply;
// the final sum is formed one stage later by exu_pipe.
module exu_alu_core import exu_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic [OP_W-1:0] op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] result
`ifdef EXU_MUL_EN
  ,
  output logic            mul_valid,
  output logic            mul_high,
  output logic [2*XLEN-1:0] pp_lo,
  output logic [XLEN-1:0] pp_hi
`endif
);

  localparam int SW = shamt_w(XLEN);

  logic [SW-1:0] shamt;
  assign shamt = b[SW-1:0];

  // Single-cycle result for all non-multiply ops; unknown codes give zero.
  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SLL:  result = a << shamt;
      OP_SRL:  result = a >> shamt;
      OP_SRA:  result = $signed(a) >>> shamt;
      OP_SLT:  result = XLEN'($signed(a) < $signed(b));
      OP_SLTU: result = XLEN'(a < b);
      OP_LUI:  result = imm;
      OP_BEQ:  result = XLEN'(a == b);
      OP_BNE:  result = XLEN'(a != b);
      OP_BLT:  result = XLEN'($signed(a) < $signed(b));
      OP_BGE:  result = XLEN'($signed(a) >= $signed(b));
      OP_BLTU: result = XLEN'(a < b);
      OP_BGEU: result = XLEN'(a >= b);
      default: result = '0;
    endcase
  end

`ifdef EXU_MUL_EN
  logic [2*XLEN-1:0] a2;
  logic [2*XLEN-1:0] b2;

  // Extend operands to 2*XLEN; the product modulo 2^(2*XLEN) of the extended
  // values is the exact signed/unsigned product. Splitting a2 into halves
  // gives one full partial product and one that only matters in its low half.
  always_comb begin
    mul_valid = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU);
    mul_high  = (op != OP_MUL);
    a2 = ((op == OP_MULH) || (op == OP_MULHSU)) ? {{XLEN{a[XLEN-1]}}, a} : {{XLEN{1'b0}}, a};
    b2 = (op == OP_MULH) ? {{XLEN{b[XLEN-1]}}, b} : {{XLEN{1'b0}}, b};
    pp_lo = {{XLEN{1'b0}}, a2[XLEN-1:0]} * b2;
    pp_hi = a2[2*XLEN-1:XLEN] * b2[XLEN-1:0];
  end
`endif

endmodule

// File: rtl/exu_pipe.sv
// exu_pipe: pipelined integer execution unit with valid/ready on both sides,
// bubble-collapsing stages, flush and global freeze (rdy_in).
// Optional multiply ops are enabled by the EXU_MUL_EN macro (needs STAGES>=2).
module exu_pipe import exu_pkg::*; #(
  parameter int XLEN     = 32,
  parameter int ROB_ID_W = 5,
  parameter int STAGES   = 3
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                rdy_in,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ROB_ID_W-1:0] in_rob_id,
  input  logic [OP_W-1:0]     in_op,
  input  logic                in_src_imm,
  input  logic [XLEN-1:0]     data_j,
  input  logic [XLEN-1:0]     data_k,
  input  logic [XLEN-1:0]     imm,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ROB_ID_W-1:0] out_rob_id,
  output logic [XLEN-1:0]     out_result
);

  if (STAGES < 1) begin : g_bad_stages
    $error("exu_pipe: STAGES must be at least 1");
  end

  logic                stage_valid [STAGES];
  logic [ROB_ID_W-1:0] stage_rob   [STAGES];
  logic [XLEN-1:0]     stage_data  [STAGES];
  logic [STAGES-1:0]   free;
  logic [XLEN-1:0]     opb;
  logic [XLEN-1:0]     alu_result;

  assign opb = in_src_imm ? imm : data_k;

`ifdef EXU_MUL_EN
  if (STAGES < 2) begin : g_bad_mul
    $error("exu_pipe: EXU_MUL_EN requires STAGES >= 2");
  end

  logic                mul_valid;
  logic                mul_high;
  logic [2*XLEN-1:0]   pp_lo;
  logic [XLEN-1:0]     pp_hi;
  logic                mul_valid_s1;
  logic                mul_high_s1;
  logic [2*XLEN-1:0]   pp_lo_s1;
  logic [XLEN-1:0]     pp_hi_s1;
  logic [2*XLEN-1:0]   mul_sum;
  logic [XLEN-1:0]     mul_word;

  exu_alu_core #(.XLEN(XLEN)) u_core (
    .op(in_op), .a(data_j), .b(opb), .imm(imm), .result(alu_result),
    .mul_valid(mul_valid), .mul_high(mul_high), .pp_lo(pp_lo), .pp_hi(pp_hi)
  );

  // Partial products travel alongside stage 1 and are summed on the way to stage 2.
  assign mul_sum  = pp_lo_s1 + {pp_hi_s1, {XLEN{1'b0}}};
  assign mul_word = mul_high_s1 ? mul_sum[2*XLEN-1:XLEN] : mul_sum[XLEN-1:0];

  // Stage-1 multiply side registers share the stage-1 load enable.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      mul_valid_s1 <= 1'b0;
      mul_high_s1  <= 1'b0;
      pp_lo_s1     <= '0;
      pp_hi_s1     <= '0;
    end else if (rdy_in && !flush && free[0] && in_valid) begin
      mul_valid_s1 <= mul_valid;
      mul_high_s1  <= mul_high;
      pp_lo_s1     <= pp_lo;
      pp_hi_s1     <= pp_hi;
    end
  end
`else
  exu_alu_core #(.XLEN(XLEN)) u_core (
    .op(in_op), .a(data_j), .b(opb), .imm(imm), .result(alu_result)
  );
`endif

  assign out_valid  = stage_valid[STAGES-1] && !flush && rdy_in;
  assign out_rob_id = stage_rob[STAGES-1];
  assign out_result = stage_data[STAGES-1];
  assign in_ready   = rdy_in && free[0];

  // A slot can load when it is empty or everything from it to the output moves.
  always_comb begin
    logic run;
    free = '0;
    run  = !stage_valid[STAGES-1] || (out_valid && out_ready);
    free[STAGES-1] = run;
    for (int i = STAGES - 2; i >= 0; i--) begin
      run     = !stage_valid[i] || run;
      free[i] = run;
    end
  end

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    logic                v_next;
    logic [ROB_ID_W-1:0] r_next;
    logic [XLEN-1:0]     d_next;

    if (gi == 0) begin : g_head
      assign v_next = in_valid;
      assign r_next = in_rob_id;
      assign d_next = alu_result;
    end else begin : g_tail
      assign v_next = stage_valid[gi-1];
      assign r_next = stage_rob[gi-1];
`ifdef EXU_MUL_EN
      if (gi == 1) begin : g_mul_sum
        assign d_next = mul_valid_s1 ? mul_word : stage_data[0];
      end else begin : g_delay
        assign d_next = stage_data[gi-1];
      end
`else
      assign d_next = stage_data[gi-1];
`endif
    end

    // Stage register: frozen while rdy_in is low, emptied by flush, loads on free.
    always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
        stage_valid[gi] <= 1'b0;
        stage_rob[gi]   <= '0;
        stage_data[gi]  <= '0;
      end else if (rdy_in) begin
        if (flush) begin
          stage_valid[gi] <= 1'b0;
        end else if (free[gi]) begin
          stage_valid[gi] <= v_next;
          if (v_next) begin
            stage_rob[gi]  <= r_next;
            stage_data[gi] <= d_next;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_exu_pipe.sv
// tb_exu_pipe: directed and random stimulus against a slot-occupancy model
// with an arithmetic reference for results. Set EXU_MUL_EN to cover multiplies.
module tb_exu_pipe;
  import exu_pkg::*;

  localparam int XLEN = 32;
  localparam int RW   = 5;
  localparam int S    = 3;

  logic            clk = 1'b0;
  logic            rst, rdy, flush, in_valid, in_ready, in_src_imm;
  logic [RW-1:0]   in_rob_id, out_rob_id;
  logic [4:0]      in_op;
  logic [XLEN-1:0] data_j, data_k, imm, out_result;
  logic            out_valid, out_ready;

  exu_pipe #(.XLEN(XLEN), .ROB_ID_W(RW), .STAGES(S)) dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_rob_id(in_rob_id),
    .in_op(in_op), .in_src_imm(in_src_imm), .data_j(data_j), .data_k(data_k),
    .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
    .out_rob_id(out_rob_id), .out_result(out_result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [RW-1:0]   rob;
    logic [XLEN-1:0] res;
    int              pos;
  } ent_t;

  ent_t            q[$];
  logic [XLEN-1:0] got [int];
  int              xfer_step [int];
  int              issue_step [int];
  int              stepno = 0;
  int              errors = 0;
  int              checks = 0;
  bit              last_acc;

  // Reference result from the operation definitions, using 64-bit arithmetic.
  function automatic logic [31:0] ref_alu(logic [4:0] op, logic [31:0] a, logic [31:0] b, logic [31:0] im);
    longint sa, sb;
    longint unsigned ua, ub;
    int sh;
    sa = $signed(a); sb = $signed(b); ua = a; ub = b; sh = int'(b % 32);
    case (op)
      OP_ADD:  return 32'(ua + ub);
      OP_SUB:  return 32'(ua - ub);
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SLL:  return 32'(ua << sh);
      OP_SRL:  return 32'(ua >> sh);
      OP_SRA:  return 32'(sa >>> sh);
      OP_SLT:  return 32'(sa < sb);
      OP_SLTU: return 32'(ua < ub);
      OP_LUI:  return im;
      OP_BEQ:  return 32'(a == b);
      OP_BNE:  return 32'(a != b);
      OP_BLT:  return 32'(sa < sb);
      OP_BGE:  return 32'(sa >= sb);
      OP_BLTU: return 32'(ua < ub);
      OP_BGEU: return 32'(ua >= ub);
`ifdef EXU_MUL_EN
      OP_MUL:    return 32'(sa * sb);
      OP_MULH:   return 32'((sa * sb) >>> 32);
      OP_MULHSU: return 32'((sa * longint'(ub)) >>> 32);
      OP_MULHU:  return 32'((ua * ub) >> 32);
`endif
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] gotv(int t);
    return got.exists(t) ? got[t] : 32'hxxxxxxxx;
  endfunction

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] op, input int tag,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] im, input logic si);
    in_valid = v; in_op = op; in_rob_id = RW'(tag);
    data_j = a; data_k = b; imm = im; in_src_imm = si;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  // One clock: compare DUT against the slot model, then advance the model.
  task automatic step();
    int n;
    bit mv[$];
    bit xfer, acc, exp_ov, exp_ir;
    logic [31:0] exp_res;
    ent_t e;
    #1;
    n = q.size();
    exp_ov = rdy && !flush && n > 0 && q[0].pos == S - 1;
    xfer   = exp_ov && out_ready;
    mv = {};
    for (int k = 0; k < n; k++) begin
      if (k == 0) mv.push_back(q[0].pos < S - 1 || xfer);
      else        mv.push_back(q[k].pos + 1 < q[k-1].pos || mv[k-1]);
    end
    exp_ir = rdy && (n == 0 || q[n-1].pos > 0 || mv[n-1]);
    chk($sformatf("in_ready@%0d", stepno), 32'(in_ready), 32'(exp_ir));
    chk($sformatf("out_valid@%0d", stepno), 32'(out_valid), 32'(exp_ov));
    if (exp_ov) begin
      chk($sformatf("out_rob_id@%0d", stepno), 32'(out_rob_id), 32'(q[0].rob));
      chk($sformatf("out_result@%0d", stepno), out_result, q[0].res);
    end
    acc = in_valid && exp_ir;
    if (xfer) begin
      got[int'(out_rob_id)] = out_result;
      xfer_step[int'(out_rob_id)] = stepno;
    end
    if (acc) issue_step[int'(in_rob_id)] = stepno;
    exp_res = ref_alu(in_op, data_j, in_src_imm ? imm : data_k, imm);
    @(posedge clk);
    if (rdy) begin
      if (flush) q.delete();
      else begin
        for (int k = 0; k < n; k++) if (mv[k]) q[k].pos = q[k].pos + 1;
        if (xfer) void'(q.pop_front());
        if (acc) begin
          e.rob = in_rob_id; e.res = exp_res; e.pos = 0;
          q.push_back(e);
        end
      end
    end
    last_acc = acc;
    stepno++;
    @(negedge clk);
  endtask

  task automatic wait_accept(input string name);
    for (int w = 0; w < 20; w++) begin
      step();
      if (last_acc) break;
    end
    chk(name, 32'(last_acc), 32'd1);
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 5'd0, 0, 0, 0, 0, 1'b0);
    @(negedge clk);
    #1;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_rob_id", 32'(out_rob_id), 32'd0);
    chk("reset_out_result", out_result, 32'd0);
    rdy = 1'b0;
    #1;
    chk("reset_rdy0_in_ready", 32'(in_ready), 32'd0);
    rdy = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back ADD / SUB with latency checks.
    drive(1'b1, OP_ADD, 3, 5, 7, 0, 1'b0); step();
    drive(1'b1, OP_SUB, 4, 5, 7, 0, 1'b0); step();
    idle(); repeat (5) step();
    chk("add_result", gotv(3), 32'd12);
    chk("sub_result", gotv(4), 32'hFFFFFFFE);
    chk("add_latency", 32'(xfer_step[3] - issue_step[3]), 32'd3);
    chk("sub_latency", 32'(xfer_step[4] - issue_step[4]), 32'd3);

    // Backpressure: fill with out_ready low, then drain in order.
    got.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, OP_ADD, 10 + i, i, 100, 0, 1'b0); step();
    end
    drive(1'b1, OP_ADD, 13, 3, 100, 0, 1'b0);
    repeat (3) step();
    chk("full_blocks_issue", 32'(last_acc), 32'd0);
    out_ready = 1'b1;
    wait_accept("fourth_accept");
    idle(); repeat (6) step();
    for (int i = 0; i < 4; i++) chk($sformatf("drain_res%0d", i), gotv(10 + i), 32'(100 + i));
    for (int i = 1; i < 4; i++) chk($sformatf("drain_order%0d", i), 32'(xfer_step[10+i] - xfer_step[10+i-1]), 32'd1);

    // Shift, unsigned compare and branch compare edge values.
    got.delete();
    drive(1'b1, OP_SRA,  20, 32'h80000000, 32'h12345678, 32'd4, 1'b1); step();
    drive(1'b1, OP_SLTU, 21, 32'd1, 32'hFFFFFFFF, 0, 1'b0); step();
    drive(1'b1, OP_BGE,  22, 32'hFFFFFFFF, 32'd0, 0, 1'b0); step();
    idle(); repeat (5) step();
    chk("sra_imm", gotv(20), 32'hF8000000);
    chk("sltu", gotv(21), 32'd1);
    chk("bge_neg", gotv(22), 32'd0);

    // Flush with three in flight plus a same-cycle issue.
    got.delete();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, OP_OR, 25 + i, 32'h10 << i, 1, 0, 1'b0); step();
    end
    flush = 1'b1;
    drive(1'b1, OP_OR, 28, 32'hAA, 1, 0, 1'b0); step();
    flush = 1'b0;
    idle(); repeat (4) step();
    for (int t = 25; t <= 28; t++) chk($sformatf("flush_gone%0d", t), 32'(got.exists(t)), 32'd0);
    drive(1'b1, OP_XOR, 29, 32'hF0F0, 32'h0FF0, 0, 1'b0); step();
    idle(); repeat (4) step();
    chk("post_flush_result", gotv(29), 32'hFF00);
    chk("post_flush_latency", 32'(xfer_step[29] - issue_step[29]), 32'd3);

    // Global freeze mid-stream.
    got.delete();
    drive(1'b1, OP_ADD, 1, 1, 1, 0, 1'b0); step();
    drive(1'b1, OP_ADD, 2, 2, 2, 0, 1'b0); step();
    drive(1'b1, OP_LUI, 5, 0, 0, 32'hABC00000, 1'b1);
    rdy = 1'b0; flush = 1'b1; step();
    flush = 1'b0; step();
    rdy = 1'b1;
    wait_accept("freeze_resume_accept");
    idle(); repeat (5) step();
    chk("freeze_r1", gotv(1), 32'd2);
    chk("freeze_r2", gotv(2), 32'd4);
    chk("freeze_r5", gotv(5), 32'hABC00000);

    // Asynchronous reset with ops in flight.
    drive(1'b1, OP_ADD, 7, 9, 9, 0, 1'b0); step();
    drive(1'b1, OP_ADD, 8, 9, 9, 0, 1'b0); step();
    idle();
    #2 rst = 1'b1;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_in_ready", 32'(in_ready), 32'd1);
    chk("async_rst_out_result", out_result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    repeat (4) step();

`ifdef EXU_MUL_EN
    got.delete();
    drive(1'b1, OP_MULH,  14, 32'h80000000, 32'h80000000, 0, 1'b0); step();
    drive(1'b1, OP_MULHU, 15, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b0); step();
    idle(); repeat (5) step();
    chk("mulh", gotv(14), 32'h40000000);
    chk("mulhu", gotv(15), 32'hFFFFFFFE);
`endif

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      rdy       = ($urandom % 12) != 0;
      flush     = ($urandom % 25) == 0;
      out_ready = ($urandom % 10) < 7;
      drive(($urandom % 10) < 7, 5'($urandom_range(0, 31)), int'($urandom % 32),
            ($urandom % 4 == 0) ? 32'($urandom % 64) : $urandom,
            ($urandom % 4 == 0) ? 32'($urandom % 40) : $urandom,
            $urandom, 1'($urandom));
      step();
    end

    rdy = 1'b1; flush = 1'b0; out_ready = 1'b1; idle();
    repeat (8) step();
    chk("final_drained", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
